ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
- ID/EX pipeline register and operand-issue stage directly upstream of the EX-stage ALU.
- Latches decoded instruction fields and register-file operands each cycle.
- Generates the 4-bit ALU control code from ALUOp/funct and applies EX/MEM and MEM/WB forwarding.
- Drives the ALU's ctrl/in0/in1 inputs, raises a load-use stall request, and passes control bits on to EX/MEM.

Parameters:
- DW, 32, datapath width (operands, immediate, forwarded results).
- RW, 5, register-number width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold ID/EX contents
- flush  in  1  insert bubble
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 slt-immediate
- id_funct  in  6  R-type funct field
- id_alu_src  in  1  1 = in1 takes immediate
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_rs, id_rt, id_rd  in  RW  register numbers
- id_reg_dst  in  1  1 = destination is rd, else rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- exm_reg_write  in  1  EX/MEM writes a register
- exm_rd  in  RW  EX/MEM destination register
- exm_result  in  DW  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB writes a register
- wb_rd  in  RW  MEM/WB destination register
- wb_result  in  DW  MEM/WB write-back data
- alu_ctrl  out  4  to ALU ctrl
- alu_in0, alu_in1  out  DW  to ALU operands
- ex_store_data  out  DW  forwarded rt value for stores
- ex_dst  out  RW  selected destination register
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control
- ex_illegal  out  1  R-type with unsupported funct
- hazard_stall  out  1  load-use stall request to ID/IF

Behaviour:
- Sequential state: all ID/EX fields, plus alu_ctrl and ex_illegal computed from id_* at latch time. Latency: 1 cycle from ID to ALU inputs.
- Priority at posedge clk: rst > flush > stall > load.
  - rst: every register cleared to 0, including alu_ctrl=0 and ex_valid=0.
  - flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg and ex_illegal cleared; data fields don't-care (hold). flush and stall together means flush.
  - stall: all registers hold.
  - Otherwise: load from id_*. ex_valid=id_valid. If id_valid=0, all control bits load as 0.
- ALU control decode:
  - alu_op 00 -> 2; 01 -> 6; 11 -> 7.
  - alu_op 10 by funct: 0x20 -> 2, 0x21 -> 2, 0x22 -> 6, 0x23 -> 6, 0x24 -> 0, 0x25 -> 1, 0x2A -> 7.
  - Any other funct -> 4'hF with ex_illegal=1 and ex_reg_write forced 0.
- ex_dst = id_reg_dst ? id_rd : id_rt, latched.
- Forwarding (combinational on registered rs/rt), evaluated separately for rs and rt:
  - If exm_reg_write and exm_rd != 0 and exm_rd == reg -> exm_result.
  - Else if wb_reg_write and wb_rd != 0 and wb_rd == reg -> wb_result.
  - Else the latched register data. EX/MEM wins over MEM/WB.
- Operand outputs: alu_in0 = fwd_rs; alu_in1 = ex_alu_src ? ex_imm : fwd_rt; ex_store_data = fwd_rt.
- hazard_stall (combinational) = ex_valid & ex_mem_read & ex_rt != 0 & id_valid & (ex_rt == id_rs | ex_rt == id_rt). Caller combines this into stall/flush; the block never self-stalls.
- Register 0 is never forwarded and never triggers a hazard.

Optional Feature:
- EX_FORWARD_EN defined: forwarding as above.
- Not defined: forwarding inputs are ignored. fwd_rs/fwd_rt equal the latched register data, so software or stalls must cover hazards. hazard_stall is unchanged.

Decomposition:
- alu_pkg holds:
  - ALU ctrl constants: AND=0, OR=1, ADD=2, SUB=6, SLT=7, BAD=15.
  - ALUOp encodings.
  - Funct constants.
- Sub-module alu_ctrl_decode: pure combinational (alu_op, funct) -> (ctrl, illegal), instantiated ahead of the pipeline register.

Test Plan:
- R-type add: alu_op=10, funct=0x20, rs_data=5, rt_data=7, load -> next cycle alu_ctrl=2, alu_in0=5, alu_in1=7, ex_valid=1.
- Illegal funct 0x3F -> alu_ctrl=15, ex_illegal=1, ex_reg_write=0 despite id_reg_write=1.
- Forwarding priority: ex_rs=3, exm_rd=3 with exm_result=100, wb_rd=3 with wb_result=200 -> alu_in0=100. Deassert exm_reg_write -> 200. Set rs=0 -> latched data regardless of forwarding.
- Load-use: ex_mem_read=1, ex_rt=4; ID presents rs=4 -> hazard_stall=1. rt=0 case -> hazard_stall=0.
- stall then flush+stall the same cycle: stall holds all outputs; flush+stall gives ex_valid=0 and all control bits 0.
- rst mid-stream, asserted while stall=1 -> next edge all outputs 0, ex_valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALU control codes, ALUOp field values, R-type funct values,
// and the registered control bundle carried from ID/EX towards EX/MEM.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_BAD = 4'd15;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLTI  = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic illegal;
  } ex_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps (ALUOp, funct) to the 4-bit ALU control code; purely combinational, zero latency.
// No flow control: the result is consumed by the ID/EX register in the same cycle.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = ALU_BAD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD:  ctrl = ALU_ADD;
      ALUOP_SUB:  ctrl = ALU_SUB;
      ALUOP_SLTI: ctrl = ALU_SLT;
      default: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: ctrl = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctrl = ALU_SUB;
          FUNCT_AND:             ctrl = ALU_AND;
          FUNCT_OR:              ctrl = ALU_OR;
          FUNCT_SLT:             ctrl = ALU_SLT;
          default: begin
            ctrl    = ALU_BAD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX register + operand issue to the ALU; 1 cycle ID->ALU inputs. Priority rst>flush>stall>load;
// raises hazard_stall on load-use, never self-stalls. EX_FORWARD_EN enables EX/MEM and MEM/WB bypass.
module ex_issue_stage
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic          id_alu_src,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_result,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] alu_in0,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_illegal,
  output logic          hazard_stall
);

  logic [3:0]    dec_ctrl;
  logic          dec_illegal;
  ex_ctrl_t      id_ctl;
  ex_ctrl_t      ex_ctl;
  logic [3:0]    ex_alu_ctrl;
  logic          ex_alu_src;
  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic [RW-1:0] ex_dst_q;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  alu_ctrl_decode u_dec (
    .alu_op  (id_alu_op),
    .funct   (id_funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // A bubble (id_valid=0) loads with every control bit cleared; illegal ops never write back.
  always_comb begin
    id_ctl            = '0;
    id_ctl.valid      = id_valid;
    id_ctl.reg_write  = id_valid & id_reg_write & ~dec_illegal;
    id_ctl.mem_read   = id_valid & id_mem_read;
    id_ctl.mem_write  = id_valid & id_mem_write;
    id_ctl.mem_to_reg = id_valid & id_mem_to_reg;
    id_ctl.illegal    = id_valid & dec_illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctl      <= '0;
      ex_alu_ctrl <= '0;
      ex_alu_src  <= 1'b0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst_q    <= '0;
    end else if (flush) begin
      ex_ctl <= '0;
    end else if (!stall) begin
      ex_ctl      <= id_ctl;
      ex_alu_ctrl <= dec_ctrl;
      ex_alu_src  <= id_alu_src;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_dst_q    <= id_reg_dst ? id_rd : id_rt;
    end
  end

`ifdef EX_FORWARD_EN
  function automatic logic [DW-1:0] fwd_sel(input logic [RW-1:0] r, input logic [DW-1:0] dflt);
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == r))
      return exm_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == r))
      return wb_result;
    else
      return dflt;
  endfunction

  assign fwd_rs = fwd_sel(ex_rs, ex_rs_data);
  assign fwd_rt = fwd_sel(ex_rt, ex_rt_data);
`else
  // Bypass inputs are intentionally ignored in this build; hazards are covered upstream.
  logic unused_fwd;
  assign unused_fwd = ^{exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result, ex_rs};
  assign fwd_rs = ex_rs_data;
  assign fwd_rt = ex_rt_data;
`endif

  assign alu_ctrl      = ex_alu_ctrl;
  assign alu_in0       = fwd_rs;
  assign alu_in1       = ex_alu_src ? ex_imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_dst        = ex_dst_q;
  assign ex_valid      = ex_ctl.valid;
  assign ex_reg_write  = ex_ctl.reg_write;
  assign ex_mem_read   = ex_ctl.mem_read;
  assign ex_mem_write  = ex_ctl.mem_write;
  assign ex_mem_to_reg = ex_ctl.mem_to_reg;
  assign ex_illegal    = ex_ctl.illegal;

  assign hazard_stall = ex_ctl.valid & ex_ctl.mem_read & (ex_rt != '0) & id_valid &
                        ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage; forwarding expectations follow EX_FORWARD_EN.
// Latency under test: 1 cycle ID->ALU inputs; checks sampled 1 time unit after posedge.
// Backpressure: stall/flush driven directly by the bench; watchdog bounds total runtime.
module tb_ex_issue_stage;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, stall, flush, id_valid, id_alu_src, id_reg_dst;
    logic [1:0]    id_alu_op;
    logic [5:0]    id_funct;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          exm_reg_write, wb_reg_write;
    logic [RW-1:0] exm_rd, wb_rd;
    logic [DW-1:0] exm_result, wb_result;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_in0, alu_in1, ex_store_data;
    logic [RW-1:0] ex_dst;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic          ex_illegal, hazard_stall;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    always #5 clk = ~clk;

    ex_issue_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_ctrl(alu_ctrl), .alu_in0(alu_in0), .alu_in1(alu_in1), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_idle();
        id_valid = 0; id_alu_op = 2'b00; id_funct = 6'h00; id_alu_src = 0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    task automatic fwd_idle();
        exm_reg_write = 0; exm_rd = '0; exm_result = '0;
        wb_reg_write = 0; wb_rd = '0; wb_result = '0;
    endtask

    initial begin
        #100000;
        if (!done) begin
            $error("FAIL timeout: test did not complete within wait limit");
            $finish;
        end
    end

    initial begin
        rst = 1; stall = 0; flush = 0;
        id_idle();
        fwd_idle();
        tick();
        check("rst_alu_ctrl", alu_ctrl, 4'd0);
        check("rst_valid", ex_valid, 1'b0);
        check("rst_in0", alu_in0, 32'd0);
        check("rst_dst", ex_dst, 5'd0);
        check("rst_hazard", hazard_stall, 1'b0);
        rst = 0;

        // R-type add
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'h20; id_rs_data = 5; id_rt_data = 7;
        id_rs = 1; id_rt = 2; id_rd = 3; id_reg_dst = 1; id_reg_write = 1;
        tick();
        check("add_ctrl", alu_ctrl, 4'd2);
        check("add_in0", alu_in0, 32'd5);
        check("add_in1", alu_in1, 32'd7);
        check("add_valid", ex_valid, 1'b1);
        check("add_dst", ex_dst, 5'd3);
        check("add_regwr", ex_reg_write, 1'b1);
        check("add_illegal", ex_illegal, 1'b0);

        // Illegal funct
        id_funct = 6'h3F;
        tick();
        check("ill_ctrl", alu_ctrl, 4'hF);
        check("ill_flag", ex_illegal, 1'b1);
        check("ill_regwr", ex_reg_write, 1'b0);
        check("ill_valid", ex_valid, 1'b1);

        // Other decodes
        id_funct = 6'h24;
        tick();
        check("and_ctrl", alu_ctrl, 4'd0);
        id_funct = 6'h25;
        tick();
        check("or_ctrl", alu_ctrl, 4'd1);
        id_funct = 6'h2A;
        tick();
        check("slt_ctrl", alu_ctrl, 4'd7);
        id_alu_op = 2'b01;
        tick();
        check("sub_ctrl", alu_ctrl, 4'd6);
        id_alu_op = 2'b11; id_alu_src = 1; id_imm = 32'h1234; id_reg_dst = 0;
        tick();
        check("slti_ctrl", alu_ctrl, 4'd7);
        check("slti_in1", alu_in1, 32'h1234);
        check("slti_store", ex_store_data, 32'd7);
        check("slti_dst", ex_dst, 5'd2);

        // Bubble: control bits load as 0
        id_valid = 0; id_reg_write = 1; id_mem_read = 1;
        tick();
        check("bub_valid", ex_valid, 1'b0);
        check("bub_regwr", ex_reg_write, 1'b0);
        check("bub_memrd", ex_mem_read, 1'b0);

        // Forwarding priority on rs
        id_idle();
        id_valid = 1; id_alu_op = 2'b00; id_rs = 3; id_rs_data = 11; id_rt = 5; id_rt_data = 44;
        tick();
        exm_reg_write = 1; exm_rd = 3; exm_result = 100;
        wb_reg_write = 1; wb_rd = 3; wb_result = 200;
        #1;
        check("fwd_exm_rs", alu_in0, FWD ? 32'd100 : 32'd11);
        check("fwd_none_rt", alu_in1, 32'd44);
        exm_reg_write = 0;
        #1;
        check("fwd_wb_rs", alu_in0, FWD ? 32'd200 : 32'd11);
        exm_reg_write = 1; exm_rd = 5;
        #1;
        check("fwd_exm_rt", alu_in1, FWD ? 32'd100 : 32'd44);
        check("fwd_exm_store", ex_store_data, FWD ? 32'd100 : 32'd44);
        check("fwd_wb_rs2", alu_in0, FWD ? 32'd200 : 32'd11);

        // Register 0 is never forwarded
        id_rs = 0; id_rs_data = 33;
        tick();
        exm_rd = 0; wb_rd = 0;
        #1;
        check("fwd_r0", alu_in0, 32'd33);
        fwd_idle();

        // Load-use hazard
        id_idle();
        id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_rt = 4; id_rs = 1;
        tick();
        check("ld_memrd", ex_mem_read, 1'b1);
        check("ld_memtoreg", ex_mem_to_reg, 1'b1);
        id_idle();
        id_valid = 1; id_rs = 4; id_rt = 9;
        #1;
        check("haz_rs", hazard_stall, 1'b1);
        id_rs = 7; id_rt = 4;
        #1;
        check("haz_rt", hazard_stall, 1'b1);
        id_rt = 8;
        #1;
        check("haz_nomatch", hazard_stall, 1'b0);
        id_rt = 4; id_valid = 0;
        #1;
        check("haz_idinv", hazard_stall, 1'b0);
        id_idle();
        id_valid = 1; id_mem_read = 1; id_rt = 0;
        tick();
        id_idle();
        id_valid = 1; id_rs = 0; id_rt = 0;
        #1;
        check("haz_r0", hazard_stall, 1'b0);

        // Stall holds, then flush+stall clears control
        id_idle();
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'h20; id_rs_data = 5; id_rt_data = 7;
        id_reg_write = 1; id_mem_write = 1; id_rd = 6; id_reg_dst = 1;
        tick();
        stall = 1;
        id_alu_op = 2'b01; id_rs_data = 99; id_rt_data = 98; id_rd = 9; id_mem_write = 0;
        tick();
        check("stl_ctrl", alu_ctrl, 4'd2);
        check("stl_in0", alu_in0, 32'd5);
        check("stl_in1", alu_in1, 32'd7);
        check("stl_dst", ex_dst, 5'd6);
        check("stl_valid", ex_valid, 1'b1);
        check("stl_regwr", ex_reg_write, 1'b1);
        check("stl_memwr", ex_mem_write, 1'b1);
        flush = 1;
        tick();
        check("fl_valid", ex_valid, 1'b0);
        check("fl_regwr", ex_reg_write, 1'b0);
        check("fl_memwr", ex_mem_write, 1'b0);
        check("fl_memrd", ex_mem_read, 1'b0);
        check("fl_memtoreg", ex_mem_to_reg, 1'b0);
        check("fl_illegal", ex_illegal, 1'b0);
        flush = 0; stall = 0;

        // Reset mid-stream while stalled
        id_idle();
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'h25; id_rs_data = 21; id_rt_data = 22;
        id_rd = 7; id_reg_dst = 1; id_reg_write = 1; id_mem_to_reg = 1; id_mem_write = 1;
        tick();
        check("pre_rst_ctrl", alu_ctrl, 4'd1);
        check("pre_rst_memwr", ex_mem_write, 1'b1);
        rst = 1; stall = 1;
        tick();
        check("mrst_ctrl", alu_ctrl, 4'd0);
        check("mrst_valid", ex_valid, 1'b0);
        check("mrst_in0", alu_in0, 32'd0);
        check("mrst_in1", alu_in1, 32'd0);
        check("mrst_dst", ex_dst, 5'd0);
        check("mrst_regwr", ex_reg_write, 1'b0);
        check("mrst_memwr", ex_mem_write, 1'b0);
        check("mrst_memtoreg", ex_mem_to_reg, 1'b0);
        rst = 0; stall = 0;

        done = 1'b1;
        if (bad != 0)
            $error("FAIL summary: %0d of %0d checks failed", bad, total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
